// File: rtl/sum_pair_packer.sv
// Stream-to-packed-pair accumulator.
// Beats are summed into lane A, then into lane B.
// The pair {sum_a, sum_b} is then held on a valid/ready output until downstream takes it.
module sum_pair_packer #(
   parameter int WIDTH   = 8,
   parameter int N_TERMS = 5
) (
   input  logic                                         clk_i,
   input  logic                                         rst_ni,
   input  logic                                         clear_i,
   input  logic                                         in_valid_i,
   output logic                                         in_ready_o,
   input  logic [WIDTH-1:0]                             in_data_i,
   output logic                                         out_valid_o,
   input  logic                                         out_ready_i,
   output logic [2*(WIDTH+$clog2(N_TERMS))-1:0]         out_data_o,
   output logic [15:0]                                  frame_cnt_o
);

   // Lane sums are wide enough to hold N_TERMS maximum-valued beats.
   localparam int SUM_W = WIDTH + $clog2(N_TERMS);
   localparam int CNT_W = $clog2(N_TERMS);
   localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(N_TERMS - 1);

   typedef enum logic [1:0] {
      ACC_A = 2'd0,
      ACC_B = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        term_cnt_q;
   logic [SUM_W-1:0]        sum_a_q, sum_b_q;
   logic                    out_valid_q;
   logic [2*SUM_W-1:0]      out_data_q;
   logic [15:0]             frame_cnt_q;

   logic                    accept;
   logic                    last_term;
   logic                    out_take;
   logic [SUM_W-1:0]        beat_ext;

   // Operands are unsigned; widen with zeros so the lane adders never sign-extend.
   function automatic logic [SUM_W-1:0] zext(input logic [WIDTH-1:0] v);
      return {{(SUM_W-WIDTH){1'b0}}, v};
   endfunction

   assign accept    = in_valid_i & in_ready_o;
   assign last_term = (term_cnt_q == LAST_TERM);
   assign out_take  = out_valid_q & out_ready_i;
   assign beat_ext  = zext(in_data_i);

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ACC_A;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode.
   // in_ready depends on state alone, so input readiness never waits on in_valid.
   always_comb begin
      state_d    = state_q;
      in_ready_o = 1'b0;
      case (state_q)
         ACC_A: begin
            in_ready_o = 1'b1;
            if (accept && last_term) state_d = ACC_B;
         end
         ACC_B: begin
            in_ready_o = 1'b1;
            if (accept && last_term) state_d = HOLD;
         end
         HOLD: begin
            if (out_take) state_d = ACC_A;
         end
         default: state_d = ACC_A;
      endcase
      if (clear_i) state_d = ACC_A;
   end

   // Term counter, lane sums and output registers.
   // clear_i overrides everything, including a pending output handshake.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         term_cnt_q  <= '0;
         sum_a_q     <= '0;
         sum_b_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         frame_cnt_q <= '0;
      end else if (clear_i) begin
         term_cnt_q  <= '0;
         sum_a_q     <= '0;
         sum_b_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         if (accept) begin
            term_cnt_q <= last_term ? '0 : term_cnt_q + 1'b1;
            if (state_q == ACC_A) begin
               sum_a_q <= sum_a_q + beat_ext;
            end else begin
               sum_b_q <= sum_b_q + beat_ext;
               if (last_term) begin
                  out_valid_q <= 1'b1;
                  out_data_q  <= {sum_a_q, sum_b_q + beat_ext};
               end
            end
         end
         if (out_take) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sum_a_q     <= '0;
            sum_b_q     <= '0;
            frame_cnt_q <= frame_cnt_q + 16'd1;
         end
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign frame_cnt_o = frame_cnt_q;

endmodule
